// File: rtl/ascon_rate_packer_if.sv
// Stream-in / block-out bus of the Ascon rate packer.
// slave is the packer's view; master is the upstream source plus downstream block consumer.
interface ascon_rate_packer_if;
    logic [63:0]  s_axis_tdata;
    logic [7:0]   s_axis_tkeep;
    logic [1:0]   s_axis_tuser;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;

    logic [127:0] blk_data;
    logic [15:0]  blk_keep;
    logic [1:0]   blk_tuser;
    logic         blk_last;
    logic [1:0]   blk_nwords;
    logic         blk_valid;
    logic         blk_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid, blk_ready,
        output s_axis_tready, blk_data, blk_keep, blk_tuser, blk_last, blk_nwords, blk_valid
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid, blk_ready,
        input  s_axis_tready, blk_data, blk_keep, blk_tuser, blk_last, blk_nwords, blk_valid
    );
endinterface

// File: rtl/ascon_rate_packer.sv
// Packs the padded 64-bit Ascon stream into 1- or 2-word rate blocks behind one output slot.
// Optional segment-type checking with sticky err_o is enabled by defining ASCON_PACKER_CHECK_EN.
package ascon_pkg;
    typedef logic [63:0] ascon_word_t;
    typedef enum logic [1:0] {
        MODE_AEAD = 2'd0,
        MODE_HASH = 2'd1,
        MODE_XOF  = 2'd2,
        MODE_CXOF = 2'd3
    } ascon_mode_t;
    typedef enum logic [1:0] {
        TUSER_AD  = 2'd0,
        TUSER_PT  = 2'd1,
        TUSER_CT  = 2'd2,
        TUSER_MSG = 2'd3
    } axi_tuser_t;
endpackage

module ascon_rate_packer
    import ascon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  ascon_mode_t        mode_i,
    ascon_rate_packer_if.slave bus,
    output logic               err_o
);
    localparam int TW = $bits(axi_tuser_t);

    typedef enum logic {ST_EMPTY = 1'b0, ST_HALF = 1'b1} state_t;

    state_t        state_q, state_d;
    ascon_word_t   hold_data_q, hold_data_d;
    logic [7:0]    hold_keep_q, hold_keep_d;
    logic [TW-1:0] hold_tuser_q, hold_tuser_d;
    logic          hold_rate2_q, hold_rate2_d;

    logic [127:0]  blk_data_q, blk_data_d;
    logic [15:0]   blk_keep_q, blk_keep_d;
    logic [TW-1:0] blk_tuser_q, blk_tuser_d;
    logic          blk_last_q, blk_last_d;
    logic [1:0]    blk_nwords_q, blk_nwords_d;
    logic          blk_valid_q, blk_valid_d;
    logic          err_q, err_d;

    logic accept, mismatch, ct_frac_err, pair, word_rate2, completes;

    assign bus.s_axis_tready = !blk_valid_q || bus.blk_ready;
    assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;

`ifdef ASCON_PACKER_CHECK_EN
    assign mismatch    = (state_q == ST_HALF) && (bus.s_axis_tuser != hold_tuser_q);
    assign ct_frac_err = (bus.s_axis_tuser == TUSER_CT) && (bus.s_axis_tkeep != 8'hFF)
                         && !bus.s_axis_tlast;
`else
    assign mismatch    = 1'b0;
    assign ct_frac_err = 1'b0;
`endif

    // A mismatching word restarts the block, so it is treated exactly like a word arriving in EMPTY.
    assign pair       = (state_q == ST_HALF) && !mismatch;
    assign word_rate2 = pair ? hold_rate2_q : (mode_i == MODE_AEAD);
    assign completes  = pair || !word_rate2 || bus.s_axis_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            hold_tuser_q <= '0;
            hold_rate2_q <= 1'b0;
            blk_data_q   <= '0;
            blk_keep_q   <= '0;
            blk_tuser_q  <= '0;
            blk_last_q   <= 1'b0;
            blk_nwords_q <= '0;
            blk_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            hold_tuser_q <= hold_tuser_d;
            hold_rate2_q <= hold_rate2_d;
            blk_data_q   <= blk_data_d;
            blk_keep_q   <= blk_keep_d;
            blk_tuser_q  <= blk_tuser_d;
            blk_last_q   <= blk_last_d;
            blk_nwords_q <= blk_nwords_d;
            blk_valid_q  <= blk_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = completes ? ST_EMPTY : ST_HALF;
        end
    end

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        hold_tuser_d = hold_tuser_q;
        hold_rate2_d = hold_rate2_q;
        blk_data_d   = blk_data_q;
        blk_keep_d   = blk_keep_q;
        blk_tuser_d  = blk_tuser_q;
        blk_last_d   = blk_last_q;
        blk_nwords_d = blk_nwords_q;
        blk_valid_d  = blk_valid_q && !bus.blk_ready;
        err_d        = err_q || (accept && (mismatch || ct_frac_err));
        if (accept) begin
            if (completes) begin
                blk_valid_d  = 1'b1;
                blk_last_d   = bus.s_axis_tlast;
                if (pair) begin
                    blk_data_d   = {hold_data_q, bus.s_axis_tdata};
                    blk_keep_d   = {hold_keep_q, bus.s_axis_tkeep};
                    blk_tuser_d  = hold_tuser_q;
                    blk_nwords_d = 2'd2;
                end else begin
                    blk_data_d   = {bus.s_axis_tdata, 64'h0};
                    blk_keep_d   = {bus.s_axis_tkeep, 8'h00};
                    blk_tuser_d  = bus.s_axis_tuser;
                    blk_nwords_d = 2'd1;
                end
            end else begin
                hold_data_d  = bus.s_axis_tdata;
                hold_keep_d  = bus.s_axis_tkeep;
                hold_tuser_d = bus.s_axis_tuser;
                hold_rate2_d = word_rate2;
            end
        end
    end

    assign bus.blk_data   = blk_data_q;
    assign bus.blk_keep   = blk_keep_q;
    assign bus.blk_tuser  = blk_tuser_q;
    assign bus.blk_last   = blk_last_q;
    assign bus.blk_nwords = blk_nwords_q;
    assign bus.blk_valid  = blk_valid_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_ascon_rate_packer.sv
// Bench for ascon_rate_packer: directed scenarios plus random segments against a segment-level model.
// Define ASCON_PACKER_CHECK_EN for both RTL and bench to exercise the checking build.
module tb_ascon_rate_packer;
    import ascon_pkg::*;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic [1:0]   tuser;
        logic         last;
        logic [1:0]   nwords;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst;
    ascon_mode_t mode;
    logic        err;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    blk_t        got_q[$];
    blk_t        exp_q[$];
    int          rand_done;

    always #5 clk = ~clk;

    ascon_rate_packer_if bus();

    ascon_rate_packer dut (
        .clk   (clk),
        .rst   (rst),
        .mode_i(mode),
        .bus   (bus),
        .err_o (err)
    );

    function automatic blk_t mk(input logic [127:0] d, input logic [15:0] k, input logic [1:0] u,
                                input logic l, input logic [1:0] n);
        blk_t b;
        b.data = d; b.keep = k; b.tuser = u; b.last = l; b.nwords = n;
        return b;
    endfunction

    // Inputs change at posedge+1, so what is seen here is what the next edge will handshake.
    always @(negedge clk) begin
        if (!rst && bus.blk_valid && bus.blk_ready)
            got_q.push_back(mk(bus.blk_data, bus.blk_keep, bus.blk_tuser, bus.blk_last, bus.blk_nwords));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic [1:0] u,
                             input logic l, output int waits);
        logic acc;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tuser  = u;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            step();
            if (acc) break;
            waits++;
            if (waits > 200) begin
                total_cnt++;
                $display("FAIL send_timeout tready stayed 0 for %0d cycles, required 1", waits);
                break;
            end
        end
    endtask

    task automatic idle();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        int c = 0;
        while (got_q.size() < n && c < 300) begin
            step();
            c++;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = MODE_AEAD;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = '0;
        bus.s_axis_tkeep = '0;
        bus.s_axis_tuser = '0;
        bus.s_axis_tlast = 1'b0;
        bus.blk_ready = 1'b1;
        #2;
        total_cnt++;
        if ({bus.blk_valid, bus.blk_last, err, bus.blk_data, bus.blk_keep, bus.blk_tuser, bus.blk_nwords} !== '0)
            $display("FAIL reset_outputs got valid=%b data=%h keep=%h nwords=%0d, required all zero",
                     bus.blk_valid, bus.blk_data, bus.blk_keep, bus.blk_nwords);
        else pass_cnt++;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.s_axis_tready !== 1'b1 || bus.blk_valid !== 1'b0)
            $display("FAIL reset_ready got tready=%b valid=%b, required 1 0", bus.s_axis_tready, bus.blk_valid);
        else pass_cnt++;
        step();
    endtask

    task automatic test_aead_ad();
        logic [63:0] a0, a1;
        blk_t exp_b;
        int w;
        a0 = {$urandom, $urandom};
        a1 = {$urandom, $urandom};
        mode = MODE_AEAD;
        got_q.delete();
        send_word(a0, 8'hFF, TUSER_AD, 1'b0, w);
        total_cnt++;
        if (bus.blk_valid !== 1'b0) $display("FAIL aead_half_valid got %b required 0", bus.blk_valid);
        else pass_cnt++;
        send_word(a1, 8'hFF, TUSER_AD, 1'b1, w);
        idle();
        total_cnt++;
        if (bus.blk_valid !== 1'b1) $display("FAIL aead_latency got valid=%b required 1", bus.blk_valid);
        else pass_cnt++;
        wait_blocks(1);
        exp_b = mk({a0, a1}, 16'hFFFF, TUSER_AD, 1'b1, 2'd2);
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== exp_b)
            $display("FAIL aead_block got n=%0d %h required n=1 %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, exp_b);
        else pass_cnt++;
    endtask

    task automatic test_hash_msg();
        logic [63:0] m [3];
        int w, waits_sum;
        blk_t exp_b;
        mode = MODE_HASH;
        got_q.delete();
        waits_sum = 0;
        for (int i = 0; i < 3; i++) m[i] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            send_word(m[i], 8'hFF, TUSER_MSG, i == 2, w);
            waits_sum += w;
        end
        idle();
        total_cnt++;
        if (waits_sum != 0) $display("FAIL hash_no_gaps got %0d stall cycles required 0", waits_sum);
        else pass_cnt++;
        wait_blocks(3);
        total_cnt++;
        if (got_q.size() != 3) $display("FAIL hash_count got %0d required 3", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            exp_b = mk({m[i], 64'h0}, 16'hFF00, TUSER_MSG, i == 2, 2'd1);
            total_cnt++;
            if (got_q[i] !== exp_b) $display("FAIL hash_block%0d got %h required %h", i, got_q[i], exp_b);
            else pass_cnt++;
        end
    endtask

    task automatic test_ct_partial();
        logic [63:0] c0;
        blk_t exp_b;
        int w;
        c0 = {$urandom, $urandom};
        mode = MODE_AEAD;
        got_q.delete();
        send_word(c0, 8'hE0, TUSER_CT, 1'b1, w);
        idle();
        wait_blocks(1);
        exp_b = mk({c0, 64'h0}, 16'hE000, TUSER_CT, 1'b1, 2'd1);
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== exp_b)
            $display("FAIL ct_partial got n=%0d %h required n=1 %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, exp_b);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [63:0] s0, s1;
        blk_t exp0, exp1;
        int w;
        s0 = {$urandom, $urandom};
        s1 = {$urandom, $urandom};
        mode = MODE_HASH;
        got_q.delete();
        bus.blk_ready = 1'b0;
        send_word(s0, 8'hFF, TUSER_MSG, 1'b0, w);
        bus.s_axis_tdata = s1;
        bus.s_axis_tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.s_axis_tready !== 1'b0) $display("FAIL stall_tready%0d got %b required 0", i, bus.s_axis_tready);
            else pass_cnt++;
            total_cnt++;
            if (bus.blk_valid !== 1'b1) $display("FAIL stall_valid%0d got %b required 1", i, bus.blk_valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.blk_data !== {s0, 64'h0})
                $display("FAIL stall_data%0d got %h required %h", i, bus.blk_data, {s0, 64'h0});
            else pass_cnt++;
            step();
        end
        bus.blk_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.s_axis_tready !== 1'b1) $display("FAIL stall_release got tready=%b required 1", bus.s_axis_tready);
        else pass_cnt++;
        step();
        idle();
        wait_blocks(2);
        exp0 = mk({s0, 64'h0}, 16'hFF00, TUSER_MSG, 1'b0, 2'd1);
        exp1 = mk({s1, 64'h0}, 16'hFF00, TUSER_MSG, 1'b1, 2'd1);
        total_cnt++;
        if (got_q.size() != 2 || got_q[0] !== exp0 || got_q[1] !== exp1)
            $display("FAIL stall_blocks got n=%0d first %h required n=2 %h then %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, exp0, exp1);
        else pass_cnt++;
    endtask

    task automatic test_mismatch();
        logic [63:0] a0, p0, p1;
        blk_t exp_b;
        int w;
        a0 = {$urandom, $urandom};
        p0 = {$urandom, $urandom};
        p1 = {$urandom, $urandom};
        mode = MODE_AEAD;
        got_q.delete();
        send_word(a0, 8'hFF, TUSER_AD, 1'b0, w);
        send_word(p0, 8'hFF, TUSER_PT, 1'b0, w);
`ifdef ASCON_PACKER_CHECK_EN
        idle();
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b1 || bus.blk_valid !== 1'b0)
            $display("FAIL mismatch_flag got err=%b valid=%b required 1 0", err, bus.blk_valid);
        else pass_cnt++;
        step();
        send_word(p1, 8'hFF, TUSER_PT, 1'b1, w);
        idle();
        wait_blocks(1);
        exp_b = mk({p0, p1}, 16'hFFFF, TUSER_PT, 1'b1, 2'd2);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL mismatch_sticky got err=%b required 1", err);
        else pass_cnt++;
`else
        idle();
        wait_blocks(1);
        p1 = '0;
        exp_b = mk({a0, p0}, 16'hFFFF, TUSER_AD, 1'b0, 2'd2);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL mismatch_noerr got err=%b required 0", err);
        else pass_cnt++;
`endif
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== exp_b)
            $display("FAIL mismatch_block got n=%0d %h required n=1 %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, exp_b);
        else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_reset got %b required 0", err);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_block();
        logic [63:0] b0, b1;
        blk_t exp_b;
        int w;
        b0 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        got_q.delete();
        mode = MODE_HASH;
        bus.blk_ready = 1'b0;
        send_word({$urandom, $urandom}, 8'hFF, TUSER_MSG, 1'b1, w);
        idle();
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.blk_valid !== 1'b0 || bus.s_axis_tready !== 1'b1)
            $display("FAIL rst_pending got valid=%b tready=%b required 0 1", bus.blk_valid, bus.s_axis_tready);
        else pass_cnt++;
        step();
        rst = 1'b0;
        bus.blk_ready = 1'b1;
        mode = MODE_AEAD;
        send_word({$urandom, $urandom}, 8'hFF, TUSER_AD, 1'b0, w);
        idle();
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.blk_valid !== 1'b0) $display("FAIL rst_half got valid=%b required 0", bus.blk_valid);
        else pass_cnt++;
        step();
        rst = 1'b0;
        step();
        send_word(b0, 8'hFF, TUSER_AD, 1'b0, w);
        send_word(b1, 8'hFF, TUSER_AD, 1'b1, w);
        idle();
        wait_blocks(1);
        exp_b = mk({b0, b1}, 16'hFFFF, TUSER_AD, 1'b1, 2'd2);
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== exp_b)
            $display("FAIL rst_repack got n=%0d %h required n=1 %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, exp_b);
        else pass_cnt++;
    endtask

    // Model: a segment of n words at rate r splits into ceil(n/r) blocks; only the final one is last.
    task automatic test_random();
        got_q.delete();
        exp_q.delete();
        rand_done = 0;
        fork
            begin
                int w;
                for (int s = 0; s < 40; s++) begin
                    logic aead;
                    logic [1:0] u;
                    int n, rate;
                    logic [63:0] words [5];
                    logic [7:0] keeps [5];
                    aead = 1'($urandom_range(0, 1));
                    mode = aead ? MODE_AEAD : MODE_HASH;
                    case ($urandom_range(0, 2))
                        0: u = TUSER_AD;
                        1: u = TUSER_PT;
                        default: u = TUSER_CT;
                    endcase
                    if (!aead) u = TUSER_MSG;
                    n = $urandom_range(1, 5);
                    rate = aead ? 2 : 1;
                    for (int i = 0; i < n; i++) begin
                        words[i] = {$urandom, $urandom};
                        keeps[i] = 8'hFF;
                    end
                    if (u == TUSER_CT) keeps[n-1] = ~(8'hFF >> $urandom_range(1, 8));
                    for (int i = 0; i < n; i += rate) begin
                        if (i + 1 < n && rate == 2)
                            exp_q.push_back(mk({words[i], words[i+1]}, {keeps[i], keeps[i+1]}, u,
                                               i + 2 >= n, 2'd2));
                        else
                            exp_q.push_back(mk({words[i], 64'h0}, {keeps[i], 8'h00}, u, i + 1 >= n, 2'd1));
                    end
                    for (int i = 0; i < n; i++) send_word(words[i], keeps[i], u, i == n - 1, w);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        step();
                    end
                end
                idle();
                rand_done = 1;
            end
            begin
                while (rand_done == 0) begin
                    bus.blk_ready = 1'($urandom_range(0, 1));
                    step();
                end
                bus.blk_ready = 1'b1;
            end
        join
        wait_blocks(exp_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL random_count got %0d required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) $display("FAIL random_block%0d got %h required %h", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (err !== 1'b0) $display("FAIL random_err got %b required 0", err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_aead_ad();
        test_hash_msg();
        test_ct_partial();
        test_stall();
        test_mismatch();
        test_reset_mid_block();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ascon_rate_packer.md
# ascon_rate_packer

Downstream neighbour of the Ascon padder. It consumes the padded 64-bit AXI4-Stream and assembles rate-sized blocks: 128 bits (two words) in AEAD modes, 64 bits (one word) in hash/XOF modes. It presents each block to the AEAD/Hash FSM datapath through one registered valid/ready output slot. Partial final blocks carry the exact fractional byte mask needed for ciphertext.

## Interface
Parameters:
- none. Widths come from `ascon_pkg` (`ascon_word_t` = 64 bits, `ascon_mode_t`, `axi_tuser_t`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode_i` in `ascon_mode_t`: AEAD mode means rate = 2 words; any other mode means rate = 1 word.
- `s_axis_tdata` in 64: padded word.
- `s_axis_tkeep` in 8: 8'hFF, except fractional on the final `TUSER_CT` word.
- `s_axis_tuser` in `axi_tuser_t`: segment type.
- `s_axis_tlast` in 1: end of the rate-aligned segment.
- `s_axis_tvalid` in 1 / `s_axis_tready` out 1: input handshake.
- `blk_data` out 128: word0 in [127:64], word1 in [63:0]; unused half is zero.
- `blk_keep` out 16: {keep0, keep1}; unused half is 8'h00.
- `blk_tuser` out `axi_tuser_t`: segment type of the block.
- `blk_last` out 1: the block closes its segment.
- `blk_nwords` out 2: 1 or 2 valid words.
- `blk_valid` out 1 / `blk_ready` in 1: block handshake.
- `err_o` out 1: sticky protocol error (see Configuration).

## Operation
- Per-block state machine:
  - EMPTY: no word held.
  - HALF: word0 is in the hold register, together with its keep, tuser and latched rate.
- Rate is sampled from `mode_i` when word0 is accepted. A change of `mode_i` while in HALF has no effect on that block.
- An accepted word completes a block if any of these hold:
  - state is HALF;
  - latched rate = 1;
  - `s_axis_tlast` = 1.
- When a word completes a block, the output register loads data/keep/tuser, sets `blk_last` = `s_axis_tlast`, sets `blk_nwords` = 2 if HALF else 1, and the state returns to EMPTY.
- When an accepted word does not complete a block: EMPTY → HALF, word stored.
- Acceptance rule: `s_axis_tready` = `!blk_valid || blk_ready`. This is a combinational path from `blk_ready`, with no dependence on `s_axis_tvalid`.
- The output register holds `blk_*` stable while `blk_valid && !blk_ready`.
- `blk_valid` clears on handshake unless a new block loads in the same cycle.
- Tuser mismatch: in HALF, an incoming word whose tuser differs from word0's tuser. Handling depends on `ASCON_PACKER_CHECK_EN`.

## Timing
- Reset (asynchronous, immediate) drives:
  - `blk_valid`, `blk_last`, `err_o` = 0;
  - `blk_data`, `blk_keep` = 0;
  - `blk_tuser` = 0 encoding;
  - `blk_nwords` = 0;
  - state EMPTY, hold register cleared.
- After reset, `s_axis_tready` = 1.
- Latency: a completing word accepted at edge N gives `blk_valid` = 1 after edge N; the block is visible in cycle N+1.
- Throughput: one word per cycle sustained while `blk_ready` = 1. AEAD produces one block per two cycles; hash produces one block per cycle.
- Back-to-back: an output handshake and a new block load in the same cycle keep `blk_valid` = 1 with the new contents.
- A stall on `blk_ready` = 0 with `blk_valid` = 1 drops `s_axis_tready` in the same cycle. The HALF hold register is unaffected.
- Reset mid-block discards the held word and any pending output block. No partial block is emitted.

## Configuration
- `ASCON_PACKER_CHECK_EN` defined:
  - On a tuser mismatch, the held word0 is discarded and `err_o` sets, staying 1 until reset.
  - The incoming word is then processed as word0 of a new block from EMPTY. It may complete immediately if rate = 1 or tlast = 1.
  - Also flagged: a `TUSER_CT` word with tkeep ≠ 8'hFF and tlast = 0.
- Undefined:
  - No mismatch detection; the incoming word becomes word1 regardless, and `blk_tuser` = word0's tuser.
  - `err_o` is tied to 0.

## Test plan
- AEAD, AD words A0,A1 (tlast on A1), `blk_ready` = 1 → one block: data {A0,A1}, keep 16'hFFFF, nwords 2, last 1, valid one cycle after A1.
- Hash, MSG words M0,M1,M2 (tlast on M2) back-to-back → three blocks, nwords 1, keep 16'hFF00, last only on M2, no `s_axis_tready` gaps.
- AEAD, CT single word with tkeep 8'hE0, tlast → data {C0, 64'h0}, keep 16'hE000, nwords 1, last 1.
- Hold `blk_ready` = 0 for 5 cycles with a block pending → `s_axis_tready` = 0 and `blk_*` stable. Release → handshake, and the next word is accepted in the same cycle.
- With CHECK_EN: AEAD, AD word then PT word → `err_o` = 1, AD word dropped, PT word held as word0. Without CHECK_EN: one block with tuser AD and `err_o` = 0.
- Assert `rst` while in HALF with a pending output → `blk_valid` drops immediately. A subsequent 2-word segment packs correctly from EMPTY.
